// File: rtl/bubble_sort_pkg.sv
// Shared types and constants for the bubble sort engine.
package bubble_sort_pkg;

   // Sort controller states
   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CMP,
      WR_LO,
      WR_HI,
      DONE
   } state_t;

   // Sort direction encoding on the mode input
   localparam logic MODE_ASC  = 1'b0;
   localparam logic MODE_DESC = 1'b1;

endpackage

// File: rtl/sort_cmp.sv
// Pairwise compare: decides whether two adjacent elements must be exchanged.
// Equal elements never swap, which keeps the sort stable.
module sort_cmp
   import bubble_sort_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              mode,
   output logic              swap
);

   // Strict compare in the selected direction
   always_comb begin
      swap = 1'b0;
      case (mode)
         MODE_ASC:  swap = (a > b);
         MODE_DESC: swap = (a < b);
         default:   swap = 1'b0;
      endcase
   end

endmodule

// File: rtl/bubble_sort_engine.sv
// In-place bubble sort over an internal register array with host write/read
// access. One compare per LOAD/CMP pair; swaps cost two extra write cycles.
module bubble_sort_engine
   import bubble_sort_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 32,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic [6:0]        pass_cnt
);

   // Last compare index of pass 0, and the index of the final possible pass
   localparam logic [ADDR_W:0]   J_LIMIT = (ADDR_W+1)'(DEPTH - 2);
   localparam logic [ADDR_W-1:0] I_LAST  = ADDR_W'(DEPTH - 2);

   state_t              state, next_state;
   logic                mode_q;
   logic                swap_flag;
   logic                swap;
   logic [ADDR_W-1:0]   i, j, j_plus1;
   logic [ADDR_W:0]     last_j;
   logic                pass_end, last_pass;
   logic [DATA_W-1:0]   reg_lo, reg_hi;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                init, load, set_flag, step_j, next_pass, adv;

   assign j_plus1   = j + 1'b1;
   assign last_j    = J_LIMIT - {1'b0, i};
   assign pass_end  = ({1'b0, j} >= last_j);
   assign last_pass = (i == I_LAST);
   assign rd_data   = mem[rd_addr];

   sort_cmp #(
      .DATA_W (DATA_W)
   ) u_cmp (
      .a    (reg_lo),
      .b    (reg_hi),
      .mode (mode_q),
      .swap (swap)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state, control strobes and the single array write port mux
   always_comb begin
      next_state = state;
      busy       = 1'b1;
      done       = 1'b0;
      init       = 1'b0;
      load       = 1'b0;
      set_flag   = 1'b0;
      step_j     = 1'b0;
      next_pass  = 1'b0;
      adv        = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = wr_addr;
      mem_wdata  = wr_data;
      case (state)
         IDLE: begin
            busy   = 1'b0;
            mem_we = wr_en;
            if (start) begin
               init       = 1'b1;
               next_state = LOAD;
            end
         end
         LOAD: begin
            load       = 1'b1;
            next_state = CMP;
         end
         CMP: begin
            if (swap) begin
               set_flag   = 1'b1;
               next_state = WR_LO;
            end else begin
               adv = 1'b1;
            end
         end
         WR_LO: begin
            mem_we     = 1'b1;
            mem_waddr  = j;
            mem_wdata  = reg_hi;
            next_state = WR_HI;
         end
         WR_HI: begin
            mem_we    = 1'b1;
            mem_waddr = j_plus1;
            mem_wdata = reg_lo;
            adv       = 1'b1;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      // Advance: next pair in this pass, next pass, or finish early/at the end
      if (adv) begin
         if (!pass_end) begin
            step_j     = 1'b1;
            next_state = LOAD;
         end else if (!swap_flag || last_pass) begin
            next_state = DONE;
         end else begin
            next_pass  = 1'b1;
            next_state = LOAD;
         end
      end
   end

   // Pass/index counters, swap tracking and the compare operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= MODE_ASC;
         i         <= '0;
         j         <= '0;
         swap_flag <= 1'b0;
         pass_cnt  <= '0;
         reg_lo    <= '0;
         reg_hi    <= '0;
      end else begin
         if (init) begin
            mode_q    <= mode;
            i         <= '0;
            j         <= '0;
            swap_flag <= 1'b0;
            pass_cnt  <= 7'd1;
         end
         if (load) begin
            reg_lo <= mem[j];
            reg_hi <= mem[j_plus1];
         end
         if (set_flag) swap_flag <= 1'b1;
         if (step_j)   j <= j_plus1;
         if (next_pass) begin
            i         <= i + 1'b1;
            j         <= '0;
            swap_flag <= 1'b0;
            pass_cnt  <= pass_cnt + 7'd1;
         end
      end
   end

   // Element storage: host writes in IDLE, swap writes during a sort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Scoreboard bench for bubble_sort_engine at DEPTH=4, DATA_W=8.
module tb_bubble_sort_engine;
   import bubble_sort_pkg::*;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;

   typedef logic [DEPTH-1:0][DATA_W-1:0] arr_t;
   typedef struct {
      arr_t arr;
      int   passes;
      int   cycles;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              mode;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              done;
   logic [6:0]        pass_cnt;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   bubble_sort_engine #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .busy     (busy),
      .done     (done),
      .pass_cnt (pass_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Build an array value with element 0 first
   function automatic arr_t mk(input int a0, input int a1, input int a2, input int a3);
      arr_t r;
      r[0] = DATA_W'(a0);
      r[1] = DATA_W'(a1);
      r[2] = DATA_W'(a2);
      r[3] = DATA_W'(a3);
      return r;
   endfunction

   // Reference: early-exit bubble sort, with the cycle cost of each step
   function automatic void model(input arr_t in, input logic m, output arr_t out,
                                 output int passes, output int cycles);
      logic [DATA_W-1:0] t;
      bit swapped;
      out    = in;
      passes = 0;
      cycles = 1;
      for (int p = 0; p < DEPTH - 1; p++) begin
         swapped = 1'b0;
         passes  = p + 1;
         for (int k = 0; k < DEPTH - 1 - p; k++) begin
            cycles += 2;
            if ((m == MODE_ASC && out[k] > out[k+1]) || (m == MODE_DESC && out[k] < out[k+1])) begin
               t        = out[k];
               out[k]   = out[k+1];
               out[k+1] = t;
               cycles  += 2;
               swapped  = 1'b1;
            end
         end
         if (!swapped) break;
      end
   endfunction

   task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(posedge clk); #1;
      wr_en   = 1'b0;
   endtask

   task automatic load_array(input arr_t v);
      for (int k = 0; k < DEPTH; k++) write_word(ADDR_W'(k), v[k]);
   endtask

   // Pulse start for one edge and push the expected outcome
   task automatic start_sort(input arr_t model_in, input logic m);
      exp_t e;
      model(model_in, m, e.arr, e.passes, e.cycles);
      sb.push_back(e);
      start = 1'b1;
      mode  = m;
      @(posedge clk); #1;
      start = 1'b0;
      wr_en = 1'b0;
   endtask

   // Count cycles after the start edge until done; optionally poke start+wr_en mid-sort
   task automatic wait_done(input int poke_at, output int cyc, output bit seen);
      cyc  = 1;
      seen = 1'b0;
      while (cyc < 200) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (poke_at != 0 && cyc == poke_at) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = 2'd0;
            wr_data = 8'd99;
         end
         @(posedge clk); #1;
         start = 1'b0;
         wr_en = 1'b0;
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (pass_cnt !== 7'd0) begin n_bad++; $display("FAIL reset_pass_cnt: got %0d want 0", pass_cnt); end
      for (int k = 0; k < DEPTH; k++) begin
         rd_addr = ADDR_W'(k); #1;
         n_cmp++; if (rd_data !== 8'd0) begin n_bad++; $display("FAIL reset_mem[%0d]: got %0d want 0", k, rd_data); end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_sorted();
      exp_t e; int cyc; bit seen;
      load_array(mk(1, 2, 3, 4));
      start_sort(mk(1, 2, 3, 4), MODE_ASC);
      wait_done(0, cyc, seen);
      e = sb.pop_front();
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL sorted_timeout: no done in %0d cycles", cyc); end
      n_cmp++; if (cyc != 7 || cyc != e.cycles) begin n_bad++; $display("FAIL sorted_latency: got %0d want 7", cyc); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL sorted_after: done=%b busy=%b want 0 0", done, busy); end
      for (int k = 0; k < DEPTH; k++) begin
         rd_addr = ADDR_W'(k); #1;
         n_cmp++; if (rd_data !== e.arr[k]) begin n_bad++; $display("FAIL sorted_mem[%0d]: got %0d want %0d", k, rd_data, e.arr[k]); end
      end
      n_cmp++; if (pass_cnt !== 7'd1) begin n_bad++; $display("FAIL sorted_pass_cnt: got %0d want 1", pass_cnt); end
   endtask

   task automatic test_reverse();
      exp_t e; int cyc; bit seen;
      load_array(mk(4, 3, 2, 1));
      start_sort(mk(4, 3, 2, 1), MODE_ASC);
      wait_done(0, cyc, seen);
      e = sb.pop_front();
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL reverse_timeout: no done in %0d cycles", cyc); end
      n_cmp++; if (cyc != e.cycles) begin n_bad++; $display("FAIL reverse_latency: got %0d want %0d", cyc, e.cycles); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL reverse_after: done=%b busy=%b want 0 0", done, busy); end
      for (int k = 0; k < DEPTH; k++) begin
         rd_addr = ADDR_W'(k); #1;
         n_cmp++; if (rd_data !== DATA_W'(k + 1)) begin n_bad++; $display("FAIL reverse_mem[%0d]: got %0d want %0d", k, rd_data, k + 1); end
      end
      n_cmp++; if (pass_cnt !== 7'd3) begin n_bad++; $display("FAIL reverse_pass_cnt: got %0d want 3", pass_cnt); end
   endtask

   task automatic test_desc();
      exp_t e; int cyc; bit seen;
      load_array(mk(1, 3, 2, 4));
      start_sort(mk(1, 3, 2, 4), MODE_DESC);
      wait_done(0, cyc, seen);
      e = sb.pop_front();
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL desc_timeout: no done in %0d cycles", cyc); end
      n_cmp++; if (cyc != e.cycles) begin n_bad++; $display("FAIL desc_latency: got %0d want %0d", cyc, e.cycles); end
      @(posedge clk); #1;
      for (int k = 0; k < DEPTH; k++) begin
         rd_addr = ADDR_W'(k); #1;
         n_cmp++; if (rd_data !== DATA_W'(4 - k)) begin n_bad++; $display("FAIL desc_mem[%0d]: got %0d want %0d", k, rd_data, 4 - k); end
      end
      n_cmp++; if (pass_cnt !== 7'(e.passes)) begin n_bad++; $display("FAIL desc_pass_cnt: got %0d want %0d", pass_cnt, e.passes); end
   endtask

   task automatic test_equal();
      exp_t e; int cyc; bit seen;
      load_array(mk(5, 5, 5, 5));
      start_sort(mk(5, 5, 5, 5), MODE_ASC);
      wait_done(0, cyc, seen);
      e = sb.pop_front();
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL equal_timeout: no done in %0d cycles", cyc); end
      n_cmp++; if (cyc != 7 || cyc != e.cycles) begin n_bad++; $display("FAIL equal_latency: got %0d want 7 (no write cycles)", cyc); end
      @(posedge clk); #1;
      for (int k = 0; k < DEPTH; k++) begin
         rd_addr = ADDR_W'(k); #1;
         n_cmp++; if (rd_data !== 8'd5) begin n_bad++; $display("FAIL equal_mem[%0d]: got %0d want 5", k, rd_data); end
      end
      n_cmp++; if (pass_cnt !== 7'd1) begin n_bad++; $display("FAIL equal_pass_cnt: got %0d want 1", pass_cnt); end
   endtask

   task automatic test_ignore_busy();
      exp_t e; int cyc; bit seen;
      load_array(mk(4, 3, 2, 1));
      start_sort(mk(4, 3, 2, 1), MODE_ASC);
      wait_done(5, cyc, seen);
      e = sb.pop_front();
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL busy_timeout: no done in %0d cycles", cyc); end
      n_cmp++; if (cyc != e.cycles) begin n_bad++; $display("FAIL busy_latency: got %0d want %0d (restart?)", cyc, e.cycles); end
      @(posedge clk); #1;
      for (int k = 0; k < DEPTH; k++) begin
         rd_addr = ADDR_W'(k); #1;
         n_cmp++; if (rd_data !== e.arr[k]) begin n_bad++; $display("FAIL busy_mem[%0d]: got %0d want %0d", k, rd_data, e.arr[k]); end
      end
      n_cmp++; if (pass_cnt !== 7'd3) begin n_bad++; $display("FAIL busy_pass_cnt: got %0d want 3", pass_cnt); end
   endtask

   task automatic test_reset_mid();
      exp_t e; int cyc; bit seen; bit saw_done;
      load_array(mk(4, 3, 2, 1));
      start = 1'b1;
      mode  = MODE_ASC;
      @(posedge clk); #1;          // LOAD
      start = 1'b0;
      @(posedge clk); #1;          // CMP
      @(posedge clk); #1;          // WR_LO
      rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", done); end
      n_cmp++; if (pass_cnt !== 7'd0) begin n_bad++; $display("FAIL midrst_pass_cnt: got %0d want 0", pass_cnt); end
      for (int k = 0; k < DEPTH; k++) begin
         rd_addr = ADDR_W'(k); #1;
         n_cmp++; if (rd_data !== 8'd0) begin n_bad++; $display("FAIL midrst_mem[%0d]: got %0d want 0", k, rd_data); end
      end
      @(posedge clk); #2;
      rst_n    = 1'b1;
      saw_done = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (done || busy) saw_done = 1'b1;
      end
      n_cmp++; if (saw_done) begin n_bad++; $display("FAIL midrst_quiet: got done/busy activity want none"); end
      load_array(mk(2, 4, 1, 3));
      start_sort(mk(2, 4, 1, 3), MODE_ASC);
      wait_done(0, cyc, seen);
      e = sb.pop_front();
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL midrst_timeout: no done in %0d cycles", cyc); end
      @(posedge clk); #1;
      for (int k = 0; k < DEPTH; k++) begin
         rd_addr = ADDR_W'(k); #1;
         n_cmp++; if (rd_data !== e.arr[k]) begin n_bad++; $display("FAIL midrst_mem_after[%0d]: got %0d want %0d", k, rd_data, e.arr[k]); end
      end
   endtask

   task automatic test_write_start();
      exp_t e; int cyc; bit seen;
      load_array(mk(9, 8, 7, 6));
      wr_en   = 1'b1;
      wr_addr = 2'd0;
      wr_data = 8'd1;
      start_sort(mk(1, 8, 7, 6), MODE_ASC);
      wait_done(0, cyc, seen);
      e = sb.pop_front();
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL wrstart_timeout: no done in %0d cycles", cyc); end
      n_cmp++; if (cyc != e.cycles) begin n_bad++; $display("FAIL wrstart_latency: got %0d want %0d", cyc, e.cycles); end
      @(posedge clk); #1;
      for (int k = 0; k < DEPTH; k++) begin
         rd_addr = ADDR_W'(k); #1;
         n_cmp++; if (rd_data !== e.arr[k]) begin n_bad++; $display("FAIL wrstart_mem[%0d]: got %0d want %0d", k, rd_data, e.arr[k]); end
      end
      n_cmp++; if (pass_cnt !== 7'(e.passes)) begin n_bad++; $display("FAIL wrstart_pass_cnt: got %0d want %0d", pass_cnt, e.passes); end
   endtask

   task automatic test_random();
      exp_t e; int cyc; bit seen; arr_t v; logic m;
      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < DEPTH; k++) v[k] = DATA_W'((t < 3) ? $urandom_range(0, 3) : $urandom_range(0, 255));
         m = (t % 2 == 1) ? MODE_DESC : MODE_ASC;
         load_array(v);
         start_sort(v, m);
         wait_done(0, cyc, seen);
         e = sb.pop_front();
         n_cmp++; if (!seen || cyc != e.cycles) begin n_bad++; $display("FAIL rand%0d_latency: got %0d want %0d", t, cyc, e.cycles); end
         @(posedge clk); #1;
         for (int k = 0; k < DEPTH; k++) begin
            rd_addr = ADDR_W'(k); #1;
            n_cmp++; if (rd_data !== e.arr[k]) begin n_bad++; $display("FAIL rand%0d_mem[%0d]: got %0d want %0d", t, k, rd_data, e.arr[k]); end
         end
         n_cmp++; if (pass_cnt !== 7'(e.passes)) begin n_bad++; $display("FAIL rand%0d_pass_cnt: got %0d want %0d", t, pass_cnt, e.passes); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      mode    = MODE_ASC;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      test_reset();
      test_sorted();
      test_reverse();
      test_desc();
      test_equal();
      test_ignore_busy();
      test_reset_mid();
      test_write_start();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bubble_sort_engine.md
BUBBLE_SORT_ENGINE -- requirements
Module: bubble_sort_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the element width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, giving the element count, legal range 2..64.
REQ-003 The block SHALL have localparam ADDR_W = clog2(DEPTH).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all state on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: begin a sort; sampled only in IDLE.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 sorts ascending, 1 sorts descending; latched at start.
REQ-008 The block SHALL have ports wr_en (input, 1), wr_addr (input, ADDR_W) and wr_data (input, DATA_W): host write port.
REQ-009 The block SHALL have ports rd_addr (input, ADDR_W) and rd_data (output, DATA_W): combinational host read of the array.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at sort completion.
REQ-012 The block SHALL have port pass_cnt, output, 7 bits: number of passes executed by the last sort.

Function
REQ-013 Storage SHALL be an internal DEPTH x DATA_W register array with one write port.
REQ-014 Host writes SHALL take effect only in IDLE; wr_en while busy SHALL be ignored.
REQ-015 The FSM SHALL have states IDLE, LOAD, CMP, WR_LO, WR_HI and DONE.
REQ-016 IDLE with start=1 SHALL go to LOAD, latch mode, clear i, j, swap_flag and pass_cnt, and set pass_cnt to 1.
REQ-017 LOAD SHALL capture reg_lo <= mem[j] and reg_hi <= mem[j+1], then go to CMP.
REQ-018 CMP SHALL assert swap when (reg_lo > reg_hi, mode 0) or (reg_lo < reg_hi, mode 1); equal elements SHALL never swap (stable).
REQ-019 CMP with swap SHALL go to WR_LO and set swap_flag.
REQ-020 CMP without swap SHALL perform the advance step of REQ-022.
REQ-021 WR_LO SHALL write mem[j] <= reg_hi; WR_HI SHALL write mem[j+1] <= reg_lo, then perform the advance step.
REQ-022 Advance step: if j < DEPTH-2-i, j <= j+1 and go to LOAD; otherwise the pass ends.
REQ-023 At pass end, if swap_flag=0 or i = DEPTH-2, the FSM SHALL go to DONE.
REQ-024 At pass end otherwise, the FSM SHALL set i <= i+1, j <= 0, swap_flag <= 0, pass_cnt <= pass_cnt+1, and go to LOAD.
REQ-025 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-026 Cycle cost SHALL be 2 cycles per non-swapping compare and 4 per swapping compare, plus 1 for DONE.
REQ-027 start asserted while busy SHALL be ignored, with no restart.
REQ-028 Simultaneous start and wr_en in IDLE SHALL perform the write and start the sort, the sort seeing the written value from LOAD onward.
REQ-029 rd_data SHALL always reflect mem[rd_addr], including during a sort, with intermediate values visible.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, pass_cnt=0, and clear i, j, swap_flag, reg_lo and reg_hi.
REQ-031 Array contents SHALL be cleared to 0 on reset.
REQ-032 Reset mid-sort SHALL abort with no done pulse; after release the block SHALL accept start normally.

Structure
REQ-033 A shared package (bubble_sort_pkg) SHALL hold the FSM state enum and the MODE_ASC/MODE_DESC constants.
REQ-034 The compare SHALL be one sub-module, sort_cmp (DATA_W parameter; inputs a, b, mode; output swap).
REQ-035 The FSM, counters and array SHALL stay in bubble_sort_engine.

Verification (DEPTH=4, DATA_W=8)
REQ-036 Load [1,2,3,4], mode 0, start -> done high 7 cycles after the start edge, array unchanged, pass_cnt=1.
REQ-037 Load [4,3,2,1], mode 0 -> array [1,2,3,4], pass_cnt=3, done pulse one cycle, busy low the cycle after.
REQ-038 Load [1,3,2,4], mode 1 -> array [4,3,2,1].
REQ-039 Load [5,5,5,5], mode 0 -> no write cycles (WR_LO never entered), pass_cnt=1.
REQ-040 Start [4,3,2,1], pulse start again and wr_en to address 0 mid-sort -> both ignored, result [1,2,3,4].
REQ-041 Assert rst_n low during WR_LO -> busy=0 immediately, array all zeros, no done; subsequent load and sort complete correctly.
